stepper_spi_peripheral: RTL and testbench
=========================================

# stepper_spi_peripheral

SPI peripheral (responder) block that receives `SIZE`-bit datagrams from an SPI master and returns a preloaded reply on MISO. It is the driver-side counterpart of the 40-bit stepper-driver SPI link. It lets the existing master-side SPI block be tested against an in-fabric driver model, and lets the FPGA act as a stepper-driver target. All SPI pins are asynchronous inputs, oversampled and edge-detected in the `clk_in` domain.

## Interface
- `SIZE`, 40: datagram length in bits; MSB first.
- `SYNC_STAGES`, 2: synchronizer depth for `sclk_in`, `cs_n_in` and `mosi_in`; minimum 2.
- `clk_in`  in  1  system clock (25 MHz on board).
- `rst_n_in`  in  1  one clock; reset is asynchronous and active-low.
- `sclk_in`  in  1  SPI clock from master; mode 3 (idles high, sampled on rising edge, data changed on falling edge).
- `cs_n_in`  in  1  chip select, active-low.
- `mosi_in`  in  1  serial data from master.
- `miso_out`  out  1  serial data to master.
- `miso_oe_out`  out  1  MISO output enable; high while a frame is active.
- `data_in`  in  SIZE  reply word; captured at frame start.
- `data_out`  out  SIZE  last complete received datagram.
- `data_valid_out`  out  1  one-cycle pulse when `data_out` is updated.
- `frame_error_out`  out  1  one-cycle pulse when a short frame is discarded.
- `busy_out`  out  1  high while a frame is active (synchronized CS asserted).

## Operation
- Inputs pass through `SYNC_STAGES` flops, then one history flop for edge detection.
- Sync and history flops reset to idle values: cs=1, sclk=1, mosi=0.
- Internal state:
  - shift register `sr[SIZE-1:0]`, shared by RX and TX;
  - bit counter `cnt`, 0..SIZE, saturating at SIZE.
- States:
  - IDLE: `busy_out`=0, `miso_oe_out`=0, `miso_out`=0.
  - ACTIVE: entered on a detected CS fall. On entry, `sr`<=`data_in`, `miso_out`<=`data_in[SIZE-1]`, `cnt`<=0, `miso_oe_out`<=1, `busy_out`<=1.
- In ACTIVE:
  - On sclk rise: `sr`<={`sr[SIZE-2:0]`, mosi_sync}; `cnt`<=min(`cnt`+1, SIZE).
  - On sclk fall with `cnt`>0: `miso_out`<=`sr[SIZE-1]`.
  - On sclk fall with `cnt`=0 (the first edge of mode 3): ignored.
- Daisy chain: bits past SIZE keep shifting. MISO then carries received bits delayed by SIZE clocks, and `sr` holds the last SIZE bits received.
- Detected CS rise returns the block to IDLE and also:
  - `cnt`=SIZE: `data_out`<=`sr`, `data_valid_out` pulses.
  - 0<`cnt`<SIZE: `data_out` unchanged, `frame_error_out` pulses.
  - `cnt`=0: no pulse.
- `data_in` changes during ACTIVE are ignored until the next frame.

## Timing
- Reset values: all outputs 0; `sr`=0; `cnt`=0; state IDLE.
- Pin-to-action latency is SYNC_STAGES+1 `clk_in` rising edges for every detected event: CS fall/rise, sclk rise/fall.
  - `miso_out` valid SYNC_STAGES+1 edges after `cs_n_in` falls.
  - `data_valid_out` high for exactly one cycle, SYNC_STAGES+1 edges after `cs_n_in` rises; `data_out` is valid in that same cycle and holds until the next valid frame.
- Master constraints:
  - sclk high and low phases each ≥ SYNC_STAGES+1 `clk_in` periods;
  - CS-fall to first sclk fall ≥ SYNC_STAGES+2 periods;
  - MISO changes SYNC_STAGES+1 edges after sclk falls, so the master samples on the rising edge.
- Simultaneous events (same detection cycle): CS rise beats an sclk edge (edge ignored); CS fall beats an sclk edge.
- Reset mid-frame: all state cleared immediately. If `cs_n_in` is still low at reset release, the sync reset value (1) causes a CS fall to be detected and a new frame starts mid-transfer. The truncated frame ends with `frame_error_out`.

## Test plan
- 40-bit frame, sclk = `clk_in`/6, MOSI 0x12_3456_789A, `data_in` 0xA5_0000_00FF → `data_out`=0x123456789A with one `data_valid_out` pulse; master captures 0xA500_0000FF on MISO.
- 80-bit frame, MOSI 0x11_1111_1111 then 0x22_2222_2222 → last 40 MISO bits = 0x1111111111; `data_out`=0x2222222222; one valid pulse.
- CS pulse after 17 sclk cycles → `frame_error_out` pulse; `data_out` keeps its previous value; no valid pulse. CS pulse with 0 sclk cycles → no pulses.
- `data_in` changed mid-frame from 0xFF_FFFF_FFFF to 0 → MISO still returns 0xFF_FFFF_FFFF; next frame returns 0.
- `rst_n_in` pulsed low after bit 20 with CS held low, then CS released after 10 more bits → all outputs 0 during reset, then exactly one `frame_error_out` pulse; next full frame is received correctly.

Source files
------------

// File: rtl/stepper_spi_peripheral.sv
// SPI mode-3 responder for SIZE-bit stepper-driver datagrams.
// Pins are oversampled in the clk_in domain; one shift register serves both RX and TX.
module stepper_spi_peripheral #(
   parameter int unsigned SIZE        = 40,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic            clk_in,
   input  logic            rst_n_in,
   input  logic            sclk_in,
   input  logic            cs_n_in,
   input  logic            mosi_in,
   output logic            miso_out,
   output logic            miso_oe_out,
   input  logic [SIZE-1:0] data_in,
   output logic [SIZE-1:0] data_out,
   output logic            data_valid_out,
   output logic            frame_error_out,
   output logic            busy_out
);

   localparam int unsigned CntW = $clog2(SIZE + 1);

   typedef enum logic {StIdle, StActive} state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sclk_hist_q, sclk_hist_d;
   logic                   cs_hist_q, cs_hist_d;
   logic [SIZE-1:0]        sr_q, sr_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic                   miso_q, miso_d;
   logic [SIZE-1:0]        data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   ferr_q, ferr_d;

   logic sclk_s, cs_s, mosi_s;
   logic sclk_rise, sclk_fall, cs_rise, cs_fall;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = ~sclk_hist_q & sclk_s;
   assign sclk_fall = sclk_hist_q & ~sclk_s;
   assign cs_rise   = ~cs_hist_q & cs_s;
   assign cs_fall   = cs_hist_q & ~cs_s;

   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n_in};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
      sclk_hist_d = sclk_s;
      cs_hist_d   = cs_s;
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      miso_d  = miso_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         StIdle: begin
            if (cs_fall) begin
               state_d = StActive;
               sr_d    = data_in;
               miso_d  = data_in[SIZE-1];
               cnt_d   = '0;
            end
         end
         StActive: begin
            // CS rise wins over any sclk edge detected in the same cycle
            if (cs_rise) begin
               state_d = StIdle;
               miso_d  = 1'b0;
               if (cnt_q == CntW'(SIZE)) begin
                  data_d  = sr_q;
                  valid_d = 1'b1;
               end else if (cnt_q != '0) begin
                  ferr_d = 1'b1;
               end
            end else if (sclk_rise) begin
               sr_d = {sr_q[SIZE-2:0], mosi_s};
               if (cnt_q != CntW'(SIZE)) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (sclk_fall && (cnt_q != '0)) begin
               // first fall of mode 3 precedes any data and leaves MISO alone
               miso_d = sr_q[SIZE-1];
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         sclk_sync_q <= '1;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_hist_q <= 1'b1;
         cs_hist_q   <= 1'b1;
         state_q     <= StIdle;
         sr_q        <= '0;
         cnt_q       <= '0;
         miso_q      <= 1'b0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         ferr_q      <= 1'b0;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         cs_sync_q   <= cs_sync_d;
         mosi_sync_q <= mosi_sync_d;
         sclk_hist_q <= sclk_hist_d;
         cs_hist_q   <= cs_hist_d;
         state_q     <= state_d;
         sr_q        <= sr_d;
         cnt_q       <= cnt_d;
         miso_q      <= miso_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         ferr_q      <= ferr_d;
      end
   end

   assign miso_out        = miso_q;
   assign miso_oe_out     = (state_q == StActive);
   assign busy_out        = (state_q == StActive);
   assign data_out        = data_q;
   assign data_valid_out  = valid_q;
   assign frame_error_out = ferr_q;

endmodule

// File: tb/tb_stepper_spi_peripheral.sv
// Directed bench: acts as SPI master, scoreboards received datagrams against data_out.
module tb_stepper_spi_peripheral;

   localparam int unsigned SIZE = 40;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            sclk, cs_n, mosi;
   logic            miso_out, miso_oe_out;
   logic [SIZE-1:0] data_in;
   logic [SIZE-1:0] data_out;
   logic            data_valid_out, frame_error_out, busy_out;

   int checks = 0;
   int errors = 0;
   int n_valid = 0;
   int n_ferr = 0;
   logic [SIZE-1:0] exp_q[$];

   stepper_spi_peripheral #(.SIZE(SIZE), .SYNC_STAGES(2)) dut (
      .clk_in         (clk),
      .rst_n_in       (rst_n),
      .sclk_in        (sclk),
      .cs_n_in        (cs_n),
      .mosi_in        (mosi),
      .miso_out       (miso_out),
      .miso_oe_out    (miso_oe_out),
      .data_in        (data_in),
      .data_out       (data_out),
      .data_valid_out (data_valid_out),
      .frame_error_out(frame_error_out),
      .busy_out       (busy_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (data_valid_out) begin
            n_valid++;
            if (exp_q.size() == 0) chk("unexpected_valid", 80'd1, 80'd0);
            else chk("data_out", 80'(data_out), 80'(exp_q.pop_front()));
         end
         if (frame_error_out) n_ferr++;
      end
   end

   task automatic cs_low();
      cs_n = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic cs_high();
      cs_n = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   // n sclk cycles at clk/6, MOSI taken from w[n-1:0] MSB first, MISO sampled on sclk rise
   task automatic bits(input int n, input logic [79:0] w, output logic [79:0] m);
      m = '0;
      for (int i = 0; i < n; i++) begin
         sclk = 1'b0;
         mosi = w[n-1-i];
         repeat (3) @(negedge clk);
         sclk = 1'b1;
         m = {m[78:0], miso_out};
         repeat (3) @(negedge clk);
      end
   endtask

   initial begin
      logic [79:0] m, m1;
      int v0, f0;
      rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b1; mosi = 1'b0; data_in = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs",
          {miso_out, miso_oe_out, data_valid_out, frame_error_out, busy_out, data_out}, '0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // basic 40-bit frame with latency checks
      data_in = 40'hA5_0000_00FF;
      cs_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("miso_before_latency", 80'(miso_out), 80'd0);
      @(negedge clk);
      chk("miso_at_latency", 80'(miso_out), 80'd1);
      chk("busy_oe_active", {busy_out, miso_oe_out}, 80'b11);
      @(negedge clk);
      exp_q.push_back(40'h12_3456_789A);
      bits(40, 80'h12_3456_789A, m);
      chk("miso_frame1", m[39:0], 40'hA5_0000_00FF);
      cs_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("valid_before_latency", 80'(data_valid_out), 80'd0);
      @(negedge clk);
      chk("valid_at_latency", 80'(data_valid_out), 80'd1);
      chk("idle_outputs", {busy_out, miso_oe_out, miso_out}, 80'd0);
      repeat (5) @(negedge clk);
      chk("valid_count1", 80'(n_valid), 80'd1);

      // 80-bit daisy chain
      data_in = '0;
      v0 = n_valid;
      cs_low();
      exp_q.push_back(40'h22_2222_2222);
      bits(80, {40'h11_1111_1111, 40'h22_2222_2222}, m);
      chk("daisy_first40", m[79:40], 40'h0);
      chk("daisy_last40", m[39:0], 40'h11_1111_1111);
      cs_high();
      chk("daisy_valid_count", 80'(n_valid - v0), 80'd1);

      // short frame and empty frame
      v0 = n_valid; f0 = n_ferr;
      cs_low();
      bits(17, 80'h1_5A5A, m);
      cs_high();
      chk("short_ferr", 80'(n_ferr - f0), 80'd1);
      chk("short_no_valid", 80'(n_valid - v0), 80'd0);
      chk("short_data_kept", 80'(data_out), 80'h22_2222_2222);
      cs_low();
      cs_high();
      chk("empty_ferr", 80'(n_ferr - f0), 80'd1);
      chk("empty_no_valid", 80'(n_valid - v0), 80'd0);

      // data_in change mid-frame is ignored until the next frame
      data_in = 40'hFF_FFFF_FFFF;
      cs_low();
      exp_q.push_back(40'h0F_0F0F_0F0F);
      bits(10, 80'(10'b0000111100), m1);
      data_in = '0;
      bits(30, 80'(30'h0F0F0F0F), m);
      chk("miso_held_reply", {m1[9:0], m[29:0]}, 40'hFF_FFFF_FFFF);
      cs_high();
      cs_low();
      exp_q.push_back(40'h3C_3C3C_3C3C);
      bits(40, 80'h3C_3C3C_3C3C, m);
      chk("miso_new_reply", m[39:0], 40'h0);
      cs_high();

      // reset mid-frame with CS held low
      data_in = 40'h01_2345_6789;
      v0 = n_valid; f0 = n_ferr;
      cs_low();
      bits(20, 80'hA_BCDE, m);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midreset_outputs",
          {miso_out, miso_oe_out, data_valid_out, frame_error_out, busy_out, data_out}, '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      bits(10, 80'h2AA, m);
      cs_high();
      chk("trunc_ferr", 80'(n_ferr - f0), 80'd1);
      chk("trunc_no_valid", 80'(n_valid - v0), 80'd0);
      chk("trunc_data_zero", 80'(data_out), 80'd0);
      cs_low();
      exp_q.push_back(40'h5A_5A5A_5A5A);
      bits(40, 80'h5A_5A5A_5A5A, m);
      chk("post_reset_miso", m[39:0], 40'h01_2345_6789);
      cs_high();
      chk("post_reset_valid", 80'(n_valid - v0), 80'd1);
      chk("post_reset_ferr", 80'(n_ferr - f0), 80'd1);

      chk("scoreboard_empty", 80'(exp_q.size()), 80'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
